pipe_sequencer: RTL and testbench
=================================

# pipe_sequencer

Central stall/flush/forward sequencer for the 3-stage RV32I pipeline (IF -> X -> W). It resolves three kinds of conflict from registered stage state:
- load-use data hazards;
- taken branches and jumps, detected in X;
- multi-cycle instruction-memory and data-memory handshakes.

It drives the hold/kill enables of the PC, IF/X and X/W pipeline registers and the ALU operand forwarding selects. It also keeps saturating stall/flush performance counters for the debug CSRs.

## Interface
Parameters:
- `CNT_W`, 16, width of the performance counters.

Ports:
- `clk`  in  1  core clock. Single clock domain; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode_x`  in  7  opcode of the instruction in X.
- `rs1_x`, `rs2_x`  in  5 each  source register fields of the instruction in X.
- `opcode_w`  in  7  opcode of the instruction in W.
- `rd_w`  in  5  destination register of the instruction in W.
- `wb_en_w`  in  1  the W instruction writes the register file.
- `redirect_x`  in  1  taken branch, JAL or JALR resolved in X this cycle.
- `imem_ready`  in  1  instruction fetch for the current PC completes this cycle.
- `dmem_ready`  in  1  data memory accepts `dmem_req` this cycle.
- `dmem_req`  out  1  issue the X load/store.
- `stall_f`  out  1  hold the PC and the IF/X register.
- `stall_x`  out  1  hold the X/W register input; X re-executes.
- `bubble_w`  out  1  load a NOP into W.
- `flush_x`  out  1  load a NOP into the IF/X register.
- `fwd_a`, `fwd_b`  out  1 each  select the W result for ALU operand A/B.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `stall_cnt`  out  CNT_W  cycles with `stall_f` = 1, saturating.
- `flush_cnt`  out  CNT_W  accepted redirects, saturating.

## Operation
Register usage of the X instruction:
- `rs1` is used by every opcode except LUI, AUIPC and JAL.
- `rs2` is used only by R-type, STORE and BRANCH.

Hazard definitions:
- A W writer is an instruction with `wb_en_w` = 1 and `rd_w` != 0.
- `fwd_a` = 1 when a W writer that is not a LOAD matches `rs1_x`, and X uses `rs1`. `fwd_b` is the same for `rs2`.
- `lduse` = 1 when the W writer is a LOAD and its `rd_w` matches a used `rs1_x` or `rs2_x`. Forwarding is 0 for that operand.

States: RUN, DWAIT, DROP. In RUN, evaluate the rules below in priority order; the first match wins.
1. `lduse`: `stall_f` = 1, `stall_x` = 1, `bubble_w` = 1, `dmem_req` = 0. Stay in RUN. The bubble removes the hazard on the next cycle.
2. X is LOAD or STORE: `dmem_req` = 1.
   - `dmem_ready` = 1: no stall.
   - `dmem_ready` = 0: `stall_f` = 1, `stall_x` = 1, `bubble_w` = 1; go to DWAIT.
3. `redirect_x`: `flush_x` = 1.
   - `imem_ready` = 0: a wrong-path fetch is outstanding, so `stall_f` = 1; go to DROP.
4. `imem_ready` = 0: `stall_f` = 1, `flush_x` = 1. W proceeds.

In DWAIT:
- `dmem_req` = 1, `stall_f` = 1, `stall_x` = 1, `bubble_w` = 1 every cycle.
- On `dmem_ready` = 1, the stall outputs deassert in that same cycle; go to RUN.
- `redirect_x` is ignored, since X is a memory op.

In DROP:
- `stall_f` = 1 and `flush_x` = 1 every cycle. The PC holds the redirect target.
- On `imem_ready` = 1, the returning wrong-path word is killed; go to RUN. The next fetch uses the target.

Counters:
- `stall_cnt` increments when `stall_f` = 1.
- `flush_cnt` increments on a redirect accepted in RUN (rule 3).
- Both saturate at all-ones.
- `cnt_clr` has priority over increment and clears to 0.

## Timing
Reset (while `rst_n` = 0, asynchronous):
- State = RUN, counters = 0.
- Outputs forced: `stall_f` = 1, `flush_x` = 1, `bubble_w` = 1, `stall_x` = 0, `dmem_req` = 0, `fwd_a` = `fwd_b` = 0.
- First normal cycle: the first rising edge after deassertion.

Decode behaviour:
- All outputs are combinational from the current state and inputs (Mealy), with zero-cycle latency.
- Only the state and counters are registered.

Hazard costs:
- Load-use costs exactly 1 cycle.
- A redirect costs 1 cycle, plus the DROP cycles.
- A dmem miss costs the number of cycles until `dmem_ready`.

Simultaneous events:
- Load-use with a memory op in X: no request is issued that cycle. The op is reissued after the bubble.
- Redirect with `imem_ready` = 0: DROP, never IWAIT.
- Reset mid-DWAIT or mid-DROP: returns to RUN immediately. The outstanding request is abandoned; memory must tolerate this.

## Structure
- Shared package `riscv_pipe_pkg`: opcode constants (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_ARI_RTYPE, OPC_ARI_ITYPE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR) and the state enum {RUN, DWAIT, DROP}.
- One combinational sub-module, `hazard_detect`. It contains the register-usage decode, the forwarding selects and `lduse`. The sequencer instantiates it and owns the state machine and counters.

## Test plan
- Load-use: W = LOAD x5, X = ADD x6,x5,x1 -> one cycle of `stall_f` = `stall_x` = `bubble_w` = 1, `fwd_a` = 0. Next cycle all 0. `stall_cnt` = 1.
- Forwarding: W = ADDI x3 (`wb_en_w` = 1), X = SUB x4,x2,x3 -> `fwd_b` = 1, `fwd_a` = 0. With `rd_w` = 0, or X = LUI x3 -> both forwarding selects 0.
- Dmem miss: X = SW, `dmem_ready` low for 3 cycles -> DWAIT, `dmem_req` held for 4 cycles. Stalls drop in the cycle `dmem_ready` rises. `stall_cnt` = 4.
- Redirect during fetch miss: `redirect_x` = 1 with `imem_ready` = 0, then `imem_ready` goes high 2 cycles later -> `flush_x` = 1 for 3 cycles, DROP, then RUN. `flush_cnt` = 1.
- Reset mid-DWAIT: assert `rst_n` = 0 asynchronously -> outputs go to their reset values at once, state = RUN, counters = 0.
- Saturation and clear: preload `stall_cnt` to 0xFFFF -> it stays 0xFFFF under further stalls. `cnt_clr` -> 0 on the next edge, even if a stall is active that cycle.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared opcode constants, sequencer state encoding and register-usage helpers
// for the 3-stage RV32I pipeline.
package riscv_pipe_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    DROP  = 2'd2
  } state_e;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_ARI_RTYPE) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/pipe_sequencer_if.sv
// Pipeline-facing bundle of the sequencer: stage decode fields, memory
// handshakes and the hold/kill/forward controls it returns.
interface pipe_sequencer_if;

  logic [6:0] opcode_x;
  logic [4:0] rs1_x;
  logic [4:0] rs2_x;
  logic [6:0] opcode_w;
  logic [4:0] rd_w;
  logic       wb_en_w;
  logic       redirect_x;
  logic       imem_ready;
  logic       dmem_ready;
  logic       dmem_req;
  logic       stall_f;
  logic       stall_x;
  logic       bubble_w;
  logic       flush_x;
  logic       fwd_a;
  logic       fwd_b;

  // Pipeline datapath side
  modport master (
    output opcode_x, rs1_x, rs2_x, opcode_w, rd_w, wb_en_w,
    output redirect_x, imem_ready, dmem_ready,
    input  dmem_req, stall_f, stall_x, bubble_w, flush_x, fwd_a, fwd_b
  );

  // Sequencer side
  modport slave (
    input  opcode_x, rs1_x, rs2_x, opcode_w, rd_w, wb_en_w,
    input  redirect_x, imem_ready, dmem_ready,
    output dmem_req, stall_f, stall_x, bubble_w, flush_x, fwd_a, fwd_b
  );

endinterface

// File: rtl/pipe_sequencer_hazard_detect.sv
// Combinational register-usage decode, W->X forwarding selects and load-use
// detection between the X and W stages.
module hazard_detect
  import riscv_pipe_pkg::*;
(
  input  logic [6:0] opcode_x,
  input  logic [4:0] rs1_x,
  input  logic [4:0] rs2_x,
  input  logic [6:0] opcode_w,
  input  logic [4:0] rd_w,
  input  logic       wb_en_w,
  output logic       fwd_a,
  output logic       fwd_b,
  output logic       lduse
);

  logic w_writer;
  logic w_load;
  logic hit_a;
  logic hit_b;

  always_comb begin
    w_writer = wb_en_w && (rd_w != 5'd0);
    w_load   = (opcode_w == OPC_LOAD);
    hit_a    = w_writer && uses_rs1(opcode_x) && (rs1_x == rd_w);
    hit_b    = w_writer && uses_rs2(opcode_x) && (rs2_x == rd_w);
    // A load result is not available in W yet, so it stalls instead of forwarding.
    fwd_a    = hit_a && !w_load;
    fwd_b    = hit_b && !w_load;
    lduse    = w_load && (hit_a || hit_b);
  end

endmodule

// File: rtl/pipe_sequencer.sv
// Stall/flush/forward sequencer for the IF -> X -> W pipeline: Mealy control
// outputs from a RUN/DWAIT/DROP state machine plus saturating perf counters.
module pipe_sequencer
  import riscv_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_sequencer_if.slave  pif,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic fwd_a_raw;
  logic fwd_b_raw;
  logic lduse;

  hazard_detect u_hazard_detect (
    .opcode_x (pif.opcode_x),
    .rs1_x    (pif.rs1_x),
    .rs2_x    (pif.rs2_x),
    .opcode_w (pif.opcode_w),
    .rd_w     (pif.rd_w),
    .wb_en_w  (pif.wb_en_w),
    .fwd_a    (fwd_a_raw),
    .fwd_b    (fwd_b_raw),
    .lduse    (lduse)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic seq_dmem_req;
  logic seq_stall_f;
  logic seq_stall_x;
  logic seq_bubble_w;
  logic seq_flush_x;
  logic redirect_acc;

  always_comb begin
    state_d      = state_q;
    seq_dmem_req = 1'b0;
    seq_stall_f  = 1'b0;
    seq_stall_x  = 1'b0;
    seq_bubble_w = 1'b0;
    seq_flush_x  = 1'b0;
    redirect_acc = 1'b0;

    unique case (state_q)
      RUN: begin
        if (lduse) begin
          seq_stall_f  = 1'b1;
          seq_stall_x  = 1'b1;
          seq_bubble_w = 1'b1;
        end else if (is_mem_op(pif.opcode_x)) begin
          seq_dmem_req = 1'b1;
          if (!pif.dmem_ready) begin
            seq_stall_f  = 1'b1;
            seq_stall_x  = 1'b1;
            seq_bubble_w = 1'b1;
            state_d      = DWAIT;
          end
        end else if (pif.redirect_x) begin
          seq_flush_x  = 1'b1;
          redirect_acc = 1'b1;
          // The wrong-path fetch still in flight must be drained before refetch.
          if (!pif.imem_ready) begin
            seq_stall_f = 1'b1;
            state_d     = DROP;
          end
        end else if (!pif.imem_ready) begin
          seq_stall_f = 1'b1;
          seq_flush_x = 1'b1;
        end
      end

      DWAIT: begin
        seq_dmem_req = 1'b1;
        if (pif.dmem_ready) begin
          state_d = RUN;
        end else begin
          seq_stall_f  = 1'b1;
          seq_stall_x  = 1'b1;
          seq_bubble_w = 1'b1;
        end
      end

      DROP: begin
        seq_stall_f = 1'b1;
        seq_flush_x = 1'b1;
        if (pif.imem_ready) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // While reset is held the pipeline is frozen with NOPs flowing into W.
  always_comb begin
    if (!rst_n) begin
      pif.dmem_req = 1'b0;
      pif.stall_f  = 1'b1;
      pif.stall_x  = 1'b0;
      pif.bubble_w = 1'b1;
      pif.flush_x  = 1'b1;
      pif.fwd_a    = 1'b0;
      pif.fwd_b    = 1'b0;
    end else begin
      pif.dmem_req = seq_dmem_req;
      pif.stall_f  = seq_stall_f;
      pif.stall_x  = seq_stall_x;
      pif.bubble_w = seq_bubble_w;
      pif.flush_x  = seq_flush_x;
      pif.fwd_a    = fwd_a_raw;
      pif.fwd_b    = fwd_b_raw;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (seq_stall_f && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (redirect_acc && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: hand-computed expectations for hazards,
// memory waits, redirects, async reset and counter saturation/clear.
module tb_pipe_sequencer;
  import riscv_pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cnt_clr;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  int          n_checks;
  int          n_fail;

  pipe_sequencer_if sif ();

  pipe_sequencer #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pif       (sif.slave),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Packed view of the control outputs: {dmem_req, stall_f, stall_x, bubble_w, flush_x, fwd_a, fwd_b}
  function automatic logic [31:0] ctl();
    return {25'd0, sif.dmem_req, sif.stall_f, sif.stall_x, sif.bubble_w,
            sif.flush_x, sif.fwd_a, sif.fwd_b};
  endfunction

  task automatic set_x(input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2);
    sif.opcode_x = opc;
    sif.rs1_x    = rs1;
    sif.rs2_x    = rs2;
  endtask

  task automatic set_w(input logic [6:0] opc, input logic [4:0] rd, input logic wb);
    sif.opcode_w = opc;
    sif.rd_w     = rd;
    sif.wb_en_w  = wb;
  endtask

  task automatic idle();
    set_x(OPC_ARI_ITYPE, 5'd0, 5'd0);
    set_w(OPC_ARI_ITYPE, 5'd0, 1'b0);
    sif.redirect_x = 1'b0;
    sif.imem_ready = 1'b1;
    sif.dmem_ready = 1'b1;
    cnt_clr        = 1'b0;
  endtask

  // Advance one clock; inputs change just after the edge, checks happen mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst_n = 1'b0;
    #13;
    // ctl order: dmem_req stall_f stall_x bubble_w flush_x fwd_a fwd_b
    check("reset_ctl", ctl(), 32'b0101100);
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_flush_cnt", flush_cnt, 0);
    rst_n = 1'b1;
    step();
    check("run_idle_ctl", ctl(), 32'b0000000);

    // Load-use: W = LW x5, X = ADD x6,x5,x1
    set_w(OPC_LOAD, 5'd5, 1'b1);
    set_x(OPC_ARI_RTYPE, 5'd5, 5'd1);
    #2 check("lduse_ctl", ctl(), 32'b0111000);
    step();
    set_w(OPC_ARI_ITYPE, 5'd0, 1'b0);
    #2 check("lduse_after_ctl", ctl(), 32'b0000000);
    check("lduse_stall_cnt", stall_cnt, 1);

    // Forwarding: W = ADDI x3, X = SUB x4,x2,x3
    set_w(OPC_ARI_ITYPE, 5'd3, 1'b1);
    set_x(OPC_ARI_RTYPE, 5'd2, 5'd3);
    #1 check("fwd_b_ctl", ctl(), 32'b0000001);
    set_x(OPC_ARI_ITYPE, 5'd3, 5'd3);
    #1 check("fwd_a_itype_ctl", ctl(), 32'b0000010);
    set_x(OPC_LUI, 5'd3, 5'd3);
    #1 check("fwd_lui_ctl", ctl(), 32'b0000000);
    set_x(OPC_ARI_RTYPE, 5'd0, 5'd0);
    set_w(OPC_ARI_ITYPE, 5'd0, 1'b1);
    #1 check("fwd_rd0_ctl", ctl(), 32'b0000000);
    set_w(OPC_ARI_ITYPE, 5'd3, 1'b0);
    set_x(OPC_ARI_RTYPE, 5'd3, 5'd3);
    #1 check("fwd_nowb_ctl", ctl(), 32'b0000000);
    set_w(OPC_ARI_ITYPE, 5'd0, 1'b0);

    // Dmem miss: SW with dmem_ready low for 3 cycles
    step();
    set_x(OPC_STORE, 5'd1, 5'd2);
    sif.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2 check($sformatf("dwait_miss%0d_ctl", i), ctl(), 32'b1111000);
      step();
    end
    sif.dmem_ready = 1'b1;
    #2 check("dwait_ready_ctl", ctl(), 32'b1000000);
    step();
    set_x(OPC_ARI_ITYPE, 5'd0, 5'd0);
    #2 check("dwait_exit_ctl", ctl(), 32'b0000000);
    check("dwait_stall_cnt", stall_cnt, 4);

    // Redirect while a fetch is outstanding
    sif.redirect_x = 1'b1;
    sif.imem_ready = 1'b0;
    #2 check("redir_miss_ctl", ctl(), 32'b0100100);
    step();
    sif.redirect_x = 1'b0;
    #2 check("drop1_ctl", ctl(), 32'b0100100);
    step();
    sif.imem_ready = 1'b1;
    #2 check("drop2_ctl", ctl(), 32'b0100100);
    step();
    #2 check("drop_exit_ctl", ctl(), 32'b0000000);
    check("drop_flush_cnt", flush_cnt, 1);
    check("drop_stall_cnt", stall_cnt, 7);

    // Load-use takes priority over a store in X: no request issued
    set_w(OPC_LOAD, 5'd7, 1'b1);
    set_x(OPC_STORE, 5'd7, 5'd0);
    #2 check("lduse_store_ctl", ctl(), 32'b0111000);
    step();
    set_w(OPC_ARI_ITYPE, 5'd0, 1'b0);
    #2 check("store_reissue_ctl", ctl(), 32'b1000000);
    step();

    // Redirect with fetch ready, then a plain fetch miss
    set_x(OPC_BRANCH, 5'd1, 5'd2);
    sif.redirect_x = 1'b1;
    #2 check("redir_hit_ctl", ctl(), 32'b0000100);
    step();
    set_x(OPC_ARI_ITYPE, 5'd0, 5'd0);
    sif.redirect_x = 1'b0;
    sif.imem_ready = 1'b0;
    #2 check("imiss_ctl", ctl(), 32'b0100100);
    step();
    sif.imem_ready = 1'b1;
    #2 check("imiss_flush_cnt", flush_cnt, 2);
    check("imiss_stall_cnt", stall_cnt, 9);

    // Redirect ignored while waiting on dmem
    set_x(OPC_LOAD, 5'd1, 5'd0);
    sif.dmem_ready = 1'b0;
    step();
    sif.redirect_x = 1'b1;
    #2 check("dwait_redir_ctl", ctl(), 32'b1111000);
    step();
    sif.dmem_ready = 1'b1;
    #2 check("dwait_redir_rdy_ctl", ctl(), 32'b1000000);
    step();
    idle();
    #2 check("dwait_redir_flush_cnt", flush_cnt, 2);
    check("dwait_redir_stall_cnt", stall_cnt, 11);

    // Async reset while in DWAIT
    set_x(OPC_LOAD, 5'd1, 5'd0);
    sif.dmem_ready = 1'b0;
    step();
    #1 check("pre_reset_dwait_ctl", ctl(), 32'b1111000);
    rst_n = 1'b0;
    #1 check("mid_reset_ctl", ctl(), 32'b0101100);
    check("mid_reset_stall_cnt", stall_cnt, 0);
    check("mid_reset_flush_cnt", flush_cnt, 0);
    set_x(OPC_ARI_ITYPE, 5'd0, 5'd0);
    #1 rst_n = 1'b1;
    step();
    // dmem_ready still low: DWAIT would assert dmem_req, RUN does not
    #1 check("post_reset_run_ctl", ctl(), 32'b0000000);
    sif.dmem_ready = 1'b1;

    // Saturation: hold a fetch miss long enough to pin stall_cnt at all-ones
    sif.imem_ready = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      step();
    end
    #1 check("sat_reach_stall_cnt", stall_cnt, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      step();
    end
    #1 check("sat_hold_stall_cnt", stall_cnt, 16'hFFFF);
    cnt_clr = 1'b1;
    #1 check("clr_stall_active", {31'd0, sif.stall_f}, 1);
    step();
    cnt_clr = 1'b0;
    #1 check("clr_stall_cnt", stall_cnt, 0);
    step();
    #1 check("clr_then_count", stall_cnt, 1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
